// File: rtl/osd_cdm_multicore_bridge_if.sv
// Register-access side and core SPR side of the multicore debug bridge.
// The bridge takes the slave view; whoever drives reg_* and models the cores takes the master view.
interface osd_cdm_multicore_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CORES  = 2
);
  logic                            reg_request;
  logic                            reg_write;
  logic [15:0]                     reg_addr;
  logic [15:0]                     reg_wdata;
  logic [15:0]                     reg_rdata;
  logic                            reg_ack;
  logic                            reg_err;
  logic [NUM_CORES-1:0]            stall;
  logic [NUM_CORES-1:0]            strobe;
  logic                            write;
  logic [14:0]                     adr;
  logic [DATA_WIDTH-1:0]           data_in;
  logic [NUM_CORES-1:0]            ack;
  logic [NUM_CORES*DATA_WIDTH-1:0] data_out;
  logic [NUM_CORES-1:0]            breakpoint;

  modport slave (
    input  reg_request, reg_write, reg_addr, reg_wdata, ack, data_out, breakpoint,
    output reg_rdata, reg_ack, reg_err, stall, strobe, write, adr, data_in
  );

  modport master (
    output reg_request, reg_write, reg_addr, reg_wdata, ack, data_out, breakpoint,
    input  reg_rdata, reg_ack, reg_err, stall, strobe, write, adr, data_in
  );
endinterface

// File: rtl/osd_cdm_multicore_bridge.sv
// Core debug access engine: 16-bit register accesses to multi-word SPR transfers on a selected core,
// with per-core stall, sticky breakpoint status and an SPR ack timeout.
module osd_cdm_multicore_bridge #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CORES   = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input logic                       clk,
  input logic                       rst,
  osd_cdm_multicore_bridge_if.slave bus
);
  localparam int         W         = DATA_WIDTH / 16;
  localparam logic [1:0] LAST_WORD = 2'(W - 1);
  // strobe stays up for exactly ACK_TIMEOUT cycles before the transfer is abandoned
  localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, CORE_WR, CORE_RD, DRAIN} state_t;
  state_t state, state_nxt;

  logic [3:0]            core_sel;
  logic [NUM_CORES-1:0]  stall_reg, bp_status, bp_prev, bp_rise, sel_mask, strobe_q;
  logic                  write_q;
  logic [14:0]           adr_q;
  logic [DATA_WIDTH-1:0] wbuf, rbuf, sel_data;
  logic [1:0]            wcnt, wcnt_nxt, store_idx;
  logic [7:0]            tcnt;
  logic                  rsp_ack_q, rsp_err_q;
  logic                  ack_sel, addr_match, in_core;
  logic                  comb_ack, comb_err, latch_adr, store_word, start_core;
  logic                  core_done, core_tmo, sel_we, stall_we, bp_w1c;
  logic [15:0]           rdata;

  // Word 0 is the most significant 16 bits.
  function automatic logic [15:0] word_of(input logic [DATA_WIDTH-1:0] v, input logic [1:0] idx);
    logic [15:0] wd;
    wd = '0;
    for (int i = 0; i < W; i++)
      if (idx == 2'(i)) wd = v[DATA_WIDTH-16*(i+1) +: 16];
    return wd;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] put_word(input logic [DATA_WIDTH-1:0] v,
                                                     input logic [1:0] idx, input logic [15:0] wd);
    logic [DATA_WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < W; i++)
      if (idx == 2'(i)) r[DATA_WIDTH-16*(i+1) +: 16] = wd;
    return r;
  endfunction

  assign sel_mask   = NUM_CORES'(1) << core_sel;
  assign ack_sel    = |(bus.ack & sel_mask);
  assign bp_rise    = bus.breakpoint & ~bp_prev;
  assign addr_match = bus.reg_addr[14:0] == adr_q;
  assign in_core    = (state == CORE_WR) || (state == CORE_RD);

  always_comb begin
    sel_data = '0;
    for (int c = 0; c < NUM_CORES; c++)
      if (core_sel == 4'(c)) sel_data = bus.data_out[c*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    store_idx  = 2'd0;
    comb_ack   = 1'b0;
    comb_err   = 1'b0;
    rdata      = '0;
    latch_adr  = 1'b0;
    store_word = 1'b0;
    start_core = 1'b0;
    core_done  = 1'b0;
    core_tmo   = 1'b0;
    sel_we     = 1'b0;
    stall_we   = 1'b0;
    bp_w1c     = 1'b0;

    if (in_core) begin
      if (ack_sel) begin
        core_done = 1'b1;
        wcnt_nxt  = 2'd1;
        state_nxt = (state == CORE_RD && W > 1) ? DRAIN : IDLE;
      end else if (tcnt == TMO_LAST) begin
        core_tmo  = 1'b1;
        state_nxt = IDLE;
      end
    end

    // While the registered completion pulse is out, the held request is the one being answered.
    if (rsp_ack_q || rsp_err_q) begin
      if (rsp_ack_q) rdata = word_of(rbuf, 2'd0);
    end else if (bus.reg_request && !bus.reg_addr[15]) begin
      case (bus.reg_addr)
        16'h0200: begin rdata = 16'(DATA_WIDTH); comb_err = bus.reg_write; end
        16'h0201: begin rdata = 16'(NUM_CORES);  comb_err = bus.reg_write; end
        16'h0202: begin
          rdata = {12'd0, core_sel};
          if (bus.reg_write) begin
            if (state != IDLE || bus.reg_wdata >= 16'(NUM_CORES)) comb_err = 1'b1;
            else                                                  sel_we   = 1'b1;
          end
        end
        16'h0203: begin rdata = 16'(stall_reg); stall_we = bus.reg_write; end
        16'h0204: begin rdata = 16'(bp_status); bp_w1c   = bus.reg_write; end
        default:  comb_err = 1'b1;
      endcase
      comb_ack = !comb_err;
    end else if (bus.reg_request) begin
      case (state)
        IDLE: begin
          latch_adr = 1'b1;
          if (bus.reg_write) begin
            store_word = 1'b1;
            if (W > 1) begin
              comb_ack  = 1'b1;
              wcnt_nxt  = 2'd1;
              state_nxt = COLLECT;
            end else begin
              start_core = 1'b1;
              state_nxt  = CORE_WR;
            end
          end else begin
            start_core = 1'b1;
            state_nxt  = CORE_RD;
          end
        end
        COLLECT: begin
          if (bus.reg_write && addr_match) begin
            store_word = 1'b1;
            store_idx  = wcnt;
            if (wcnt == LAST_WORD) begin
              start_core = 1'b1;
              state_nxt  = CORE_WR;
            end else begin
              comb_ack = 1'b1;
              wcnt_nxt = wcnt + 2'd1;
            end
          end else begin
            comb_err  = 1'b1;
            state_nxt = IDLE;
          end
        end
        DRAIN: begin
          if (!bus.reg_write && addr_match) begin
            comb_ack = 1'b1;
            rdata    = word_of(rbuf, wcnt);
            if (wcnt == LAST_WORD) state_nxt = IDLE;
            else                   wcnt_nxt  = wcnt + 2'd1;
          end else begin
            comb_err  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_ack_q <= 1'b0;
      rsp_err_q <= 1'b0;
      wcnt      <= '0;
      tcnt      <= '0;
      strobe_q  <= '0;
      write_q   <= 1'b0;
      adr_q     <= '0;
      wbuf      <= '0;
      core_sel  <= '0;
      stall_reg <= '0;
      bp_status <= '0;
      bp_prev   <= '0;
    end else begin
      rsp_ack_q <= core_done;
      rsp_err_q <= core_tmo;
      wcnt      <= wcnt_nxt;
      if (start_core) begin
        strobe_q <= sel_mask;
        write_q  <= bus.reg_write;
        tcnt     <= '0;
      end else if (core_done || core_tmo) begin
        strobe_q <= '0;
        write_q  <= 1'b0;
      end else if (in_core) begin
        tcnt <= tcnt + 8'd1;
      end
      if (latch_adr)  adr_q    <= bus.reg_addr[14:0];
      if (store_word) wbuf     <= put_word(wbuf, store_idx, bus.reg_wdata);
      if (sel_we)     core_sel <= bus.reg_wdata[3:0];
      // A breakpoint edge beats a same-cycle stall write or W1C clear.
      stall_reg <= (stall_we ? bus.reg_wdata[NUM_CORES-1:0] : stall_reg) | bp_rise;
      bp_status <= (bp_status & ~(bp_w1c ? bus.reg_wdata[NUM_CORES-1:0] : '0)) | bp_rise;
      bp_prev   <= bus.breakpoint;
    end
  end

  always_ff @(posedge clk) begin
    if (core_done && state == CORE_RD) rbuf <= sel_data;
  end

  assign bus.reg_ack   = comb_ack | rsp_ack_q;
  assign bus.reg_err   = comb_err | rsp_err_q;
  assign bus.reg_rdata = rdata;
  assign bus.stall     = stall_reg;
  assign bus.strobe    = strobe_q;
  assign bus.write     = write_q;
  assign bus.adr       = adr_q;
  assign bus.data_in   = wbuf;
endmodule
